// File: rtl/axil_arbiter_rr_wr_pkg.sv
// ============================================================================
// Module : axil_arb_pkg
// Shared types and helpers for the AXI-Lite per-slave arbiters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axil_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } arb_wr_state_t;

  localparam int TIMEOUT_CNT_W = 16;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_arbiter_rr_wr_if.sv
// ============================================================================
// Module : axil_arbiter_rr_wr_if
// Request/handshake/grant bundle between the write crossbar and its arbiter.
// Optional watchdog output is present with AXIL_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axil_arbiter_rr_wr_if
  import axil_arb_pkg::*;
#(
  parameter int NUMBER_MASTER = 2
) ();

  localparam int GRANT_W = grant_width(NUMBER_MASTER);

  logic [NUMBER_MASTER-1:0] request_wr;
  logic                     s_axil_awvalid;
  logic                     s_axil_awready;
  logic                     s_axil_wvalid;
  logic                     s_axil_wready;
  logic                     s_axil_bvalid;
  logic                     s_axil_bready;
  logic [GRANT_W-1:0]       grant_wr;
  logic                     grant_valid;
`ifdef AXIL_ARB_TIMEOUT_EN
  logic                     timeout_pulse;
`endif

  // Arbiter side
  modport slave (
    input  request_wr,
    input  s_axil_awvalid, s_axil_awready,
    input  s_axil_wvalid,  s_axil_wready,
    input  s_axil_bvalid,  s_axil_bready,
`ifdef AXIL_ARB_TIMEOUT_EN
    output timeout_pulse,
`endif
    output grant_wr,
    output grant_valid
  );

  // Crossbar side
  modport master (
    output request_wr,
    output s_axil_awvalid, s_axil_awready,
    output s_axil_wvalid,  s_axil_wready,
    output s_axil_bvalid,  s_axil_bready,
`ifdef AXIL_ARB_TIMEOUT_EN
    input  timeout_pulse,
`endif
    input  grant_wr,
    input  grant_valid
  );

endinterface

`default_nettype wire

// File: rtl/axil_rr_pick.sv
// ============================================================================
// Module : axil_rr_pick
// Combinational round-robin picker: first set request scanning from rr_ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_rr_pick
  import axil_arb_pkg::*;
#(
  parameter  int NUMBER_MASTER = 2,
  localparam int GRANT_W       = grant_width(NUMBER_MASTER)
) (
  input  logic [NUMBER_MASTER-1:0] request,
  input  logic [GRANT_W-1:0]       rr_ptr,
  output logic [GRANT_W-1:0]       pick,
  output logic                     any_req
);

  generate
    if (NUMBER_MASTER == 1) begin : g_single
      assign pick    = '0;
      assign any_req = request[0];
    end else begin : g_multi
      always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUMBER_MASTER; i++) begin
          idx = int'(rr_ptr) + i;
          if (idx >= NUMBER_MASTER) idx = idx - NUMBER_MASTER;
          if (!any_req && request[idx]) begin
            any_req = 1'b1;
            pick    = GRANT_W'(idx);
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/axil_arbiter_rr_wr.sv
// ============================================================================
// Module : axil_arbiter_rr_wr
// Per-slave round-robin write arbiter; grant held from pick through B.
// Optional watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_arbiter_rr_wr
  import axil_arb_pkg::*;
#(
  parameter int NUMBER_MASTER  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 aclk,
  input  logic                 areset,
  axil_arbiter_rr_wr_if.slave  bus
);

  localparam int GRANT_W = grant_width(NUMBER_MASTER);

  arb_wr_state_t      state_q,   state_d;
  logic [GRANT_W-1:0] grant_q,   grant_d;
  logic               gvalid_q,  gvalid_d;
  logic [GRANT_W-1:0] rr_ptr_q,  rr_ptr_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q,  w_done_d;

  logic [GRANT_W-1:0] pick;
  logic               any_req;
  logic               aw_hs, w_hs, b_hs;
  logic               aw_now, w_now;
  logic               req_granted;
  logic [GRANT_W-1:0] next_ptr;

  axil_rr_pick #(
    .NUMBER_MASTER (NUMBER_MASTER)
  ) u_pick (
    .request (bus.request_wr),
    .rr_ptr  (rr_ptr_q),
    .pick    (pick),
    .any_req (any_req)
  );

  // Handshakes outside an active grant belong to nobody and are ignored
  assign aw_hs       = bus.s_axil_awvalid & bus.s_axil_awready & gvalid_q;
  assign w_hs        = bus.s_axil_wvalid  & bus.s_axil_wready  & gvalid_q;
  assign b_hs        = bus.s_axil_bvalid  & bus.s_axil_bready  & gvalid_q;
  assign aw_now      = aw_done_q | aw_hs;
  assign w_now       = w_done_q  | w_hs;
  assign req_granted = bus.request_wr[grant_q];
  assign next_ptr    = (grant_q == GRANT_W'(NUMBER_MASTER - 1)) ? '0 : grant_q + 1'b1;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_W-1:0] tcnt_q, tcnt_d;
  logic                     tpulse_q, tpulse_d;

  assign bus.timeout_pulse = tpulse_q;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gvalid_d  = gvalid_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef AXIL_ARB_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    tpulse_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = ADDR_DATA;
          grant_d  = pick;
          gvalid_d = 1'b1;
        end
      end
      ADDR_DATA: begin
        if (aw_now && w_now) begin
          state_d   = RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        // Release only when nothing of the burst has been accepted yet
        end else if (!aw_now && !w_now && !req_granted) begin
          state_d  = IDLE;
          gvalid_d = 1'b0;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d  = IDLE;
          gvalid_d = 1'b0;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d  = IDLE;
        gvalid_d = 1'b0;
      end
    endcase

`ifdef AXIL_ARB_TIMEOUT_EN
    if (state_q == IDLE) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
      // A B handshake landing on the last cycle counts as completion
      if (tcnt_q == TIMEOUT_LAST && !(state_q == RESP && b_hs)) begin
        state_d   = IDLE;
        gvalid_d  = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        rr_ptr_d  = next_ptr;
        tpulse_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gvalid_q  <= 1'b0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
      tcnt_q    <= '0;
      tpulse_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gvalid_q  <= gvalid_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef AXIL_ARB_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      tpulse_q  <= tpulse_d;
`endif
    end
  end

  assign bus.grant_wr    = grant_q;
  assign bus.grant_valid = gvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_arbiter_rr_wr.sv
// ============================================================================
// Module : tb_axil_arbiter_rr_wr
// Scoreboard bench for the round-robin write arbiter, four masters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axil_arbiter_rr_wr;

  localparam int N = 4;

  logic aclk;
  logic areset;

  axil_arbiter_rr_wr_if #(.NUMBER_MASTER(N)) bus ();

  axil_arbiter_rr_wr #(
    .NUMBER_MASTER  (N),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int model_ptr = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic wait_gv(input logic level, output int cycles);
    cycles = 0;
    while (bus.grant_valid !== level && cycles < 32) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_aw();
    bus.s_axil_awvalid = 1'b1; bus.s_axil_awready = 1'b1;
    tick();
    bus.s_axil_awvalid = 1'b0; bus.s_axil_awready = 1'b0;
  endtask

  task automatic do_w();
    bus.s_axil_wvalid = 1'b1; bus.s_axil_wready = 1'b1;
    tick();
    bus.s_axil_wvalid = 1'b0; bus.s_axil_wready = 1'b0;
  endtask

  task automatic do_b();
    bus.s_axil_bvalid = 1'b1; bus.s_axil_bready = 1'b1;
    tick();
    bus.s_axil_bvalid = 1'b0; bus.s_axil_bready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    n_tests++;
    if (bus.grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_gv: got %0b want 0", bus.grant_valid);
    end
    n_tests++;
    if (bus.grant_wr !== 2'd0) begin
      n_fail++; $display("FAIL reset_grant: got %0d want 0", bus.grant_wr);
    end
`ifdef AXIL_ARB_TIMEOUT_EN
    n_tests++;
    if (bus.timeout_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse: got %0b want 0", bus.timeout_pulse);
    end
`endif
    model_ptr = 0;
  endtask

  task automatic test_round_robin();
    int cyc, e;
    bus.request_wr = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(model_pick(4'b1111, model_ptr));
      wait_gv(1'b1, cyc);
      e = exp_q.pop_front();
      n_tests++;
      if (cyc != 1) begin
        n_fail++; $display("FAIL rr_gap_%0d: got %0d cycles want 1", k, cyc);
      end
      n_tests++;
      if (bus.grant_wr !== 2'(e)) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %0d want %0d", k, bus.grant_wr, e);
      end
      model_ptr = (e + 1) % N;
      do_aw();
      do_w();
      if (k == 4) bus.request_wr = '0;
      do_b();
      n_tests++;
      if (bus.grant_valid !== 1'b0) begin
        n_fail++; $display("FAIL rr_release_%0d: got %0b want 0", k, bus.grant_valid);
      end
    end
  endtask

  task automatic test_same_cycle_hs();
    int cyc, e;
    bus.request_wr = 4'b0100;
    exp_q.push_back(2);
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e) || cyc != 1) begin
      n_fail++; $display("FAIL same_grant: got %0d after %0d want %0d after 1", bus.grant_wr, cyc, e);
    end
    bus.s_axil_awvalid = 1'b1; bus.s_axil_awready = 1'b1;
    bus.s_axil_wvalid  = 1'b1; bus.s_axil_wready  = 1'b1;
    tick();
    bus.s_axil_awvalid = 1'b0; bus.s_axil_awready = 1'b0;
    bus.s_axil_wvalid  = 1'b0; bus.s_axil_wready  = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (bus.grant_valid !== 1'b1 || bus.grant_wr !== 2'd2) begin
      n_fail++; $display("FAIL same_hold_resp: got gv=%0b g=%0d want gv=1 g=2", bus.grant_valid, bus.grant_wr);
    end
    bus.request_wr = '0;
    do_b();
    n_tests++;
    if (bus.grant_valid !== 1'b0 || bus.grant_wr !== 2'd2) begin
      n_fail++; $display("FAIL same_release: got gv=%0b g=%0d want gv=0 g=2", bus.grant_valid, bus.grant_wr);
    end
    model_ptr = 3;
    bus.request_wr = 4'b1111;
    exp_q.push_back(model_pick(4'b1111, model_ptr));
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e)) begin
      n_fail++; $display("FAIL same_ptr_adv: got %0d want %0d", bus.grant_wr, e);
    end
    do_aw();
    bus.request_wr = '0;
    do_w();
    do_b();
    model_ptr = (e + 1) % N;
  endtask

  task automatic test_hold_after_hs();
    int cyc, e;
    bus.request_wr = 4'b0010;
    exp_q.push_back(1);
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e)) begin
      n_fail++; $display("FAIL hold_grant: got %0d want %0d", bus.grant_wr, e);
    end
    do_w();
    bus.request_wr = 4'b1000;
    repeat (3) tick();
    n_tests++;
    if (bus.grant_valid !== 1'b1 || bus.grant_wr !== 2'd1) begin
      n_fail++; $display("FAIL hold_kept: got gv=%0b g=%0d want gv=1 g=1", bus.grant_valid, bus.grant_wr);
    end
    do_aw();
    do_b();
    n_tests++;
    if (bus.grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got %0b want 0", bus.grant_valid);
    end
    exp_q.push_back(3);
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e) || cyc != 1) begin
      n_fail++; $display("FAIL hold_next: got %0d after %0d want %0d after 1", bus.grant_wr, cyc, e);
    end
    do_aw();
    bus.request_wr = '0;
    do_w();
    do_b();
    model_ptr = 0;
  endtask

  task automatic test_release_no_hs();
    int cyc, e;
    bus.request_wr = 4'b0001;
    exp_q.push_back(0);
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e)) begin
      n_fail++; $display("FAIL rel_grant: got %0d want %0d", bus.grant_wr, e);
    end
    bus.request_wr = '0;
    tick();
    n_tests++;
    if (bus.grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL rel_drop: got %0b want 0", bus.grant_valid);
    end
    bus.request_wr = 4'b0011;
    exp_q.push_back(model_pick(4'b0011, model_ptr));
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e) || cyc != 1) begin
      n_fail++; $display("FAIL rel_regrant: got %0d after %0d want %0d after 1", bus.grant_wr, cyc, e);
    end
    do_aw();
    bus.request_wr = '0;
    do_w();
    do_b();
    model_ptr = (e + 1) % N;
  endtask

  task automatic test_reset_mid();
    int cyc, e;
    bus.request_wr = 4'b1000;
    exp_q.push_back(model_pick(4'b1000, model_ptr));
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e)) begin
      n_fail++; $display("FAIL rst_grant: got %0d want %0d", bus.grant_wr, e);
    end
    bus.s_axil_awvalid = 1'b1; bus.s_axil_awready = 1'b1;
    bus.s_axil_wvalid  = 1'b1; bus.s_axil_wready  = 1'b1;
    tick();
    bus.s_axil_awvalid = 1'b0; bus.s_axil_awready = 1'b0;
    bus.s_axil_wvalid  = 1'b0; bus.s_axil_wready  = 1'b0;
    bus.request_wr = '0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    n_tests++;
    if (bus.grant_valid !== 1'b0 || bus.grant_wr !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid: got gv=%0b g=%0d want gv=0 g=0", bus.grant_valid, bus.grant_wr);
    end
    model_ptr = 0;
    bus.request_wr = 4'b1010;
    exp_q.push_back(model_pick(4'b1010, model_ptr));
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e) || e != 1) begin
      n_fail++; $display("FAIL rst_after: got %0d want 1", bus.grant_wr);
    end
    do_aw();
    bus.request_wr = '0;
    do_w();
    do_b();
    model_ptr = (e + 1) % N;
  endtask

`ifdef AXIL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, e;
    bus.request_wr = 4'b1100;
    exp_q.push_back(model_pick(4'b1100, model_ptr));
    wait_gv(1'b1, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.grant_wr !== 2'(e)) begin
      n_fail++; $display("FAIL to_grant: got %0d want %0d", bus.grant_wr, e);
    end
    cyc = 0;
    while (bus.timeout_pulse !== 1'b1 && cyc < 32) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != 8 || bus.grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse: got %0d cycles gv=%0b want 8 cycles gv=0", cyc, bus.grant_valid);
    end
    model_ptr = (e + 1) % N;
    exp_q.push_back(model_pick(4'b1100, model_ptr));
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (bus.timeout_pulse !== 1'b0 || bus.grant_valid !== 1'b1 || bus.grant_wr !== 2'(e)) begin
      n_fail++; $display("FAIL to_next: got p=%0b gv=%0b g=%0d want p=0 gv=1 g=%0d",
                         bus.timeout_pulse, bus.grant_valid, bus.grant_wr, e);
    end
    do_aw();
    bus.request_wr = '0;
    do_w();
    do_b();
    model_ptr = (e + 1) % N;
  endtask
`endif

  initial begin
    areset             = 1'b1;
    bus.request_wr     = '0;
    bus.s_axil_awvalid = 1'b0; bus.s_axil_awready = 1'b0;
    bus.s_axil_wvalid  = 1'b0; bus.s_axil_wready  = 1'b0;
    bus.s_axil_bvalid  = 1'b0; bus.s_axil_bready  = 1'b0;
    test_reset();
    test_round_robin();
    test_same_cycle_hs();
    test_hold_after_hs();
    test_release_no_hs();
    test_reset_mid();
`ifdef AXIL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
